// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: S-box, widths, round count and the controller FSM states.
package present_pkg;

  localparam int STATE_W        = 64;
  localparam int KEY_W          = 80;
  localparam int CNT_W          = 5;
  localparam int PRESENT_ROUNDS = 31;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] nib);
    return SBOX[nib];
  endfunction

endpackage

// File: rtl/present_key_update.sv
// PRESENT-80 key schedule step: rotate left 61, S-box the top nibble, XOR round counter into [19:15].
module present_key_update
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] kr,
  input  logic [CNT_W-1:0] i,
  output logic [KEY_W-1:0] kr_next
);

  logic [KEY_W-1:0] rotated;

  assign rotated = {kr[18:0], kr[79:19]};

  always_comb begin
    kr_next          = rotated;
    kr_next[79:76]   = sbox4(rotated[79:76]);
    kr_next[19:15]   = rotated[19:15] ^ i;
  end

endmodule

// File: rtl/round.sv
// Single PRESENT round, purely combinational: r = P(S(x ^ k[79:16])).
module round
  import present_pkg::*;
(
  output logic [STATE_W-1:0] r,
  input  logic [STATE_W-1:0] x,
  input  logic [KEY_W-1:0]   k
);

  logic [STATE_W-1:0] keyed;
  logic [STATE_W-1:0] subst;

  assign keyed = x ^ k[KEY_W-1:KEY_W-STATE_W];

  for (genvar g = 0; g < STATE_W / 4; g++) begin : g_sbox
    assign subst[4*g+3 -: 4] = sbox4(keyed[4*g+3 -: 4]);
  end

  // Bit b moves to 16*b mod 63; bit 63 stays in place.
  for (genvar b = 0; b < STATE_W; b++) begin : g_perm
    assign r[(b == 63) ? 63 : (b * 16) % 63] = subst[b];
  end

endmodule

// File: rtl/present_ctrl.sv
// Iterative PRESENT-80 encryption controller with a four-phase req/ack handshake.
// Define PRESENT_CTRL_ABORT_EN to let a dropped req abort a transaction in RUN or FINAL.
module present_ctrl
  import present_pkg::*;
#(
  parameter int ROUNDS = PRESENT_ROUNDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [STATE_W-1:0] x,
  input  logic [KEY_W-1:0]   k,
  output logic               ack,
  output logic [STATE_W-1:0] r
);

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS);

  state_t             state, state_next;
  logic [STATE_W-1:0] s, s_next;
  logic [KEY_W-1:0]   kr, kr_next;
  logic [CNT_W-1:0]   i, i_next;
  logic [STATE_W-1:0] r_next;
  logic               ack_next;
  logic [STATE_W-1:0] round_out;
  logic [KEY_W-1:0]   kr_step;

  round u_round (
    .r (round_out),
    .x (s),
    .k (kr)
  );

  present_key_update u_key_update (
    .kr      (kr),
    .i       (i),
    .kr_next (kr_step)
  );

  always_comb begin
    // NOTE: every output of this block gets its hold value first, so no path can infer a latch.
    state_next = state;
    s_next     = s;
    kr_next    = kr;
    i_next     = i;
    r_next     = r;
    ack_next   = ack;

    unique case (state)
      IDLE: begin
        if (req && !ack) begin
          s_next     = x;
          kr_next    = k;
          i_next     = CNT_W'(1);
          state_next = RUN;
        end
      end

      RUN: begin
        s_next  = round_out;
        kr_next = kr_step;
        // Counter parks on the last round instead of wrapping.
        if (i == LAST_ROUND) state_next = FINAL;
        else                 i_next     = i + CNT_W'(1);
`ifdef PRESENT_CTRL_ABORT_EN
        if (!req) state_next = IDLE;
`endif
      end

      FINAL: begin
        r_next     = s ^ kr[KEY_W-1:KEY_W-STATE_W];
        ack_next   = 1'b1;
        state_next = DONE;
`ifdef PRESENT_CTRL_ABORT_EN
        if (!req) begin
          r_next     = r;
          ack_next   = 1'b0;
          state_next = IDLE;
        end
`endif
      end

      DONE: begin
        if (!req) begin
          ack_next   = 1'b0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      s     <= '0;
      kr    <= '0;
      i     <= '0;
      r     <= '0;
      ack   <= 1'b0;
    end else begin
      state <= state_next;
      s     <= s_next;
      kr    <= kr_next;
      i     <= i_next;
      r     <= r_next;
      ack   <= ack_next;
    end
  end

endmodule
